// File: rtl/vga_fb_writer.sv
// Frame buffer write-port sequencer: one-cycle pixel writes plus a full-screen clear engine.
// Pixel writes appear 1 cycle after accept; clear writes start 2 cycles after clr_req, one address per cycle, and cmd_ready stays low for the whole clear.
module vga_fb_writer #(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [10:0]       cmd_x,
   input  logic [10:0]       cmd_y,
   input  logic [2:0]        cmd_color,
   input  logic              clr_req,
   input  logic [2:0]        clr_color,
   output logic              busy,
   output logic              clr_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_write_address,
   output logic [2:0]        ram_d
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
   localparam logic [10:0]       V_LIM     = 11'(V_ACTIVE);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [2:0]          col_q, col_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2:0]          dat_q, dat_d;
   logic                done_q, done_d;

   logic                pix_in_range;
   logic [ADDR_W-1:0]   pix_addr;

   assign cmd_ready         = (state_q == IDLE) & ~clr_req;
   assign busy              = (state_q == CLEAR);
   assign clr_done          = done_q;
   assign ram_we            = we_q;
   assign ram_write_address = addr_q;
   assign ram_d             = dat_q;

   // Product formed at 32 bits so in-range coordinates are exact before truncation.
   assign pix_in_range = (cmd_x < H_LIM) && (cmd_y < V_LIM);
   assign pix_addr     = ADDR_W'(32'(cmd_y) * 32'(H_ACTIVE) + 32'(cmd_x));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      dat_d   = dat_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
               col_d   = clr_color;
            end else if (cmd_valid && pix_in_range) begin
               we_d   = 1'b1;
               addr_d = pix_addr;
               dat_d  = cmd_color;
            end
         end
         CLEAR: begin
            // done_q marks the cycle the final write is on the port; leave afterwards.
            if (done_q) begin
               state_d = IDLE;
            end else begin
               we_d   = 1'b1;
               addr_d = cnt_q;
               dat_d  = col_q;
               done_d = (cnt_q == LAST_ADDR);
               if (cnt_q != LAST_ADDR) begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         col_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         dat_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Bench for vga_fb_writer: full-size (800x480) and small (8x4) instances checked against a cycle-indexed write-schedule model.
module tb_vga_fb_writer;

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [1:0]  cmd_valid;
   logic [1:0]  cmd_ready;
   logic [10:0] cmd_x [2];
   logic [10:0] cmd_y [2];
   logic [2:0]  cmd_color [2];
   logic [1:0]  clr_req;
   logic [2:0]  clr_color [2];
   logic [1:0]  busy;
   logic [1:0]  clr_done;
   logic [1:0]  ram_we;
   logic [18:0] ram_addr [2];
   logic [2:0]  ram_d [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_fb_writer #(.H_ACTIVE(800), .V_ACTIVE(480), .ADDR_W(19)) dut_big (
      .clk(clk), .reset(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_x(cmd_x[0]), .cmd_y(cmd_y[0]), .cmd_color(cmd_color[0]),
      .clr_req(clr_req[0]), .clr_color(clr_color[0]), .busy(busy[0]), .clr_done(clr_done[0]),
      .ram_we(ram_we[0]), .ram_write_address(ram_addr[0]), .ram_d(ram_d[0]));

   vga_fb_writer #(.H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(19)) dut_small (
      .clk(clk), .reset(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_x(cmd_x[1]), .cmd_y(cmd_y[1]), .cmd_color(cmd_color[1]),
      .clr_req(clr_req[1]), .clr_color(clr_color[1]), .busy(busy[1]), .clr_done(clr_done[1]),
      .ram_we(ram_we[1]), .ram_write_address(ram_addr[1]), .ram_d(ram_d[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Pixel writes are scheduled by target cycle; a clear is a window of cycles
   // whose write address is simply the offset from the accepting cycle.
   typedef struct {
      int          made;
      logic [18:0] a;
      logic [2:0]  d;
   } pw_t;

   pw_t        sched [int];
   int         busy_lo [2];
   int         busy_hi [2];
   int         clr_start [2];
   int         last_rst [2];
   logic [2:0] m_col [2];

   function automatic int h_of(input int u);
      return (u == 0) ? 800 : 8;
   endfunction
   function automatic int v_of(input int u);
      return (u == 0) ? 480 : 4;
   endfunction

   initial begin
      for (int u = 0; u < 2; u++) begin
         busy_lo[u] = 0; busy_hi[u] = -1; clr_start[u] = -100; last_rst[u] = 0; m_col[u] = '0;
      end
   end

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         int          t;
         bit          m_busy, e_we, e_done;
         logic [18:0] ea;
         logic [2:0]  ed;
         string       s;
         s = $sformatf("u%0d c%0d", u, cyc);
         t = h_of(u) * v_of(u);
         if (rst[u]) begin
            chk({s, " rst we"}, 32'(ram_we[u]), 0);
            chk({s, " rst busy"}, 32'(busy[u]), 0);
            chk({s, " rst done"}, 32'(clr_done[u]), 0);
            chk({s, " rst addr"}, 32'(ram_addr[u]), 0);
            chk({s, " rst d"}, 32'(ram_d[u]), 0);
            chk({s, " rst ready"}, 32'(cmd_ready[u]), 32'(!clr_req[u]));
            last_rst[u] = cyc; busy_hi[u] = -1; clr_start[u] = -100;
         end else begin
            m_busy = (cyc >= busy_lo[u]) && (cyc <= busy_hi[u]);
            e_we = 0; e_done = 0; ea = '0; ed = '0;
            if (m_busy && cyc >= clr_start[u] + 2) begin
               e_we = 1; ea = 19'(cyc - clr_start[u] - 2); ed = m_col[u];
               e_done = (int'(ea) == t - 1);
            end else if (sched.exists(cyc * 2 + u) && sched[cyc * 2 + u].made > last_rst[u]) begin
               e_we = 1; ea = sched[cyc * 2 + u].a; ed = sched[cyc * 2 + u].d;
            end
            chk({s, " ready"}, 32'(cmd_ready[u]), 32'(!m_busy && !clr_req[u]));
            chk({s, " busy"}, 32'(busy[u]), 32'(m_busy));
            chk({s, " we"}, 32'(ram_we[u]), 32'(e_we));
            chk({s, " done"}, 32'(clr_done[u]), 32'(e_done));
            if (e_we) begin
               chk({s, " addr"}, 32'(ram_addr[u]), 32'(ea));
               chk({s, " d"}, 32'(ram_d[u]), 32'(ed));
            end
            if (!m_busy && clr_req[u]) begin
               clr_start[u] = cyc; busy_lo[u] = cyc + 1; busy_hi[u] = cyc + 1 + t;
               m_col[u] = clr_color[u];
            end else if (!m_busy && cmd_valid[u]) begin
               if (int'(cmd_x[u]) < h_of(u) && int'(cmd_y[u]) < v_of(u))
                  sched[(cyc + 1) * 2 + u] = '{cyc, 19'(int'(cmd_y[u]) * h_of(u) + int'(cmd_x[u])), cmd_color[u]};
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic drive(input int u, input bit v, input int x, input int y, input int c);
      cmd_valid[u] = v; cmd_x[u] = 11'(x); cmd_y[u] = 11'(y); cmd_color[u] = 3'(c);
   endtask

   int bx [3] = '{0, 799, 799};
   int by [3] = '{0, 0, 479};
   int bc [3] = '{1, 2, 7};
   int ba [3] = '{0, 799, 383999};

   initial begin
      int n_wr, n_done, done_addr, k;
      bit ok;
      rst = 2'b11; cmd_valid = '0; clr_req = '0;
      for (int u = 0; u < 2; u++) begin
         cmd_x[u] = '0; cmd_y[u] = '0; cmd_color[u] = '0; clr_color[u] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ready", 32'(cmd_ready[0]), 1);
      chk("reset we", 32'(ram_we[0]), 0);
      tick; rst = 2'b00;

      // single write (5,2,5) -> addr 1605
      drive(0, 1, 5, 2, 5);
      @(negedge clk); chk("single ready", 32'(cmd_ready[0]), 1);
      tick; drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("single we", 32'(ram_we[0]), 1);
      chk("single addr", 32'(ram_addr[0]), 1605);
      chk("single d", 32'(ram_d[0]), 5);
      tick; @(negedge clk); chk("single we after", 32'(ram_we[0]), 0);

      // back-to-back writes
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i < 3) drive(0, 1, bx[i], by[i], bc[i]); else drive(0, 0, 0, 0, 0);
         if (i > 0) begin
            @(negedge clk);
            chk($sformatf("b2b%0d addr", i - 1), 32'(ram_addr[0]), 32'(ba[i - 1]));
            chk($sformatf("b2b%0d d", i - 1), 32'(ram_d[0]), 32'(bc[i - 1]));
            chk($sformatf("b2b%0d we", i - 1), 32'(ram_we[0]), 1);
         end
      end

      // out-of-range pixels are accepted and dropped
      tick; drive(0, 1, 800, 0, 3);
      @(negedge clk); chk("oor x ready", 32'(cmd_ready[0]), 1);
      tick; drive(0, 1, 0, 480, 3);
      @(negedge clk); chk("oor x we", 32'(ram_we[0]), 0); chk("oor y ready", 32'(cmd_ready[0]), 1);
      tick; drive(0, 0, 0, 0, 0);
      @(negedge clk); chk("oor y we", 32'(ram_we[0]), 0);

      // small clear, colour 3, with a stray clr_req mid-clear
      tick; clr_req[1] = 1; clr_color[1] = 3'b011;
      tick; clr_req[1] = 0; clr_color[1] = 3'b110;
      @(negedge clk); chk("sclr busy rise", 32'(busy[1]), 1);
      n_wr = 0; n_done = 0; done_addr = -1; k = 0;
      while (k < 40) begin
         tick;
         clr_req[1] = (k == 10);
         @(negedge clk);
         if (ram_we[1]) begin
            if (ram_addr[1] != 19'(n_wr) || ram_d[1] != 3'd3) n_done += 100;
            n_wr++;
         end
         if (clr_done[1]) begin n_done++; done_addr = int'(ram_addr[1]); end
         k++;
      end
      clr_req[1] = 0;
      chk("sclr writes", 32'(n_wr), 32);
      chk("sclr done count", 32'(n_done), 1);
      chk("sclr done addr", 32'(done_addr), 31);
      chk("sclr ready back", 32'(cmd_ready[1]), 1);

      // priority: clr_req beats cmd_valid; pixel (1,1,6) goes in after the clear
      tick; clr_req[1] = 1; clr_color[1] = 3'b010; drive(1, 1, 1, 1, 6);
      @(negedge clk); chk("prio ready", 32'(cmd_ready[1]), 0);
      tick; clr_req[1] = 0;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready[1]) ok = 1; else tick;
      end
      chk("prio wait bound", 32'(ok), 1);
      tick; drive(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("prio pix we", 32'(ram_we[1]), 1);
      chk("prio pix addr", 32'(ram_addr[1]), 9);
      chk("prio pix d", 32'(ram_d[1]), 6);

      // full-size clear, reset while the counter sits at 1000
      tick; clr_req[0] = 1; clr_color[0] = 3'b100;
      tick; clr_req[0] = 0;
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (ram_we[0] && ram_addr[0] == 19'd999) ok = 1;
      end
      chk("fclr reach 999", 32'(ok), 1);
      @(posedge clk); #1 rst[0] = 1; #1;
      chk("fclr rst we", 32'(ram_we[0]), 0);
      chk("fclr rst busy", 32'(busy[0]), 0);
      chk("fclr rst done", 32'(clr_done[0]), 0);
      tick; tick; rst[0] = 0;
      n_wr = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); if (ram_we[0]) n_wr++;
         tick;
      end
      chk("post rst writes", 32'(n_wr), 0);
      chk("post rst ready", 32'(cmd_ready[0]), 1);
      chk("post rst busy", 32'(busy[0]), 0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
